// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared CPU defines for stall vectors and pipeline-control FSM states
package pipe_ctrl_pkg;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;
endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// stall_wdt: counts consecutive stalled cycles and latches a sticky timeout at WDT_LIMIT
module stall_wdt #(
  parameter int WDT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  output logic o_timeout
);
  localparam logic [7:0] LIMIT = 8'(WDT_LIMIT);
  logic [7:0] r_run;
  logic [7:0] w_run_nxt;
  logic       r_timeout;
  assign w_run_nxt = !i_stall ? 8'd0 : (r_run == LIMIT) ? LIMIT : r_run + 8'd1;
  assign o_timeout = r_timeout;
  // run length clears on any unstalled cycle; timeout sticks once the limit is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_run     <= w_run_nxt;
      r_timeout <= r_timeout | (w_run_nxt == LIMIT);
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall priority, exception flush sequencing and stall performance/watchdog counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WDT_LIMIT = 255,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  input  logic [31:0]      epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wdt_timeout
);
  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_hold;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [5:0]       w_prio;
  logic             w_capture;
  assign w_prio = stallreq_mem ? STALL_MEM :
                  stallreq_ex  ? STALL_EX  :
                  stallreq_id  ? STALL_ID  :
                  stallreq_if  ? STALL_IF  : STALL_NONE;
  assign w_capture    = (r_state == RUN) && flush_req && stallreq_mem;
  assign stall_cycles = r_stall_cycles;
  // a flush blocked by a memory transaction waits in PEND; a flush always overrides lower stalls
  always_comb begin
    w_state_nxt = r_state;
    stall       = w_prio;
    flush       = 1'b0;
    new_pc      = 32'h0;
    if (rst) begin
      stall = STALL_NONE;
    end else if (r_state == PEND) begin
      if (!stallreq_mem) begin
        stall       = STALL_NONE;
        flush       = 1'b1;
        new_pc      = r_hold;
        w_state_nxt = RUN;
      end
    end else if (flush_req) begin
      if (stallreq_mem) begin
        w_state_nxt = PEND;
      end else begin
        stall  = STALL_NONE;
        flush  = 1'b1;
        new_pc = epc_i;
      end
    end
  end
  // state, deferred handler PC and saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_hold         <= 32'h0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_hold <= epc_i;
      if (stall[0] && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end
  stall_wdt #(.WDT_LIMIT(WDT_LIMIT)) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .i_stall  (stall[0]),
    .o_timeout(wdt_timeout)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table vectors, directed corner sequences and random stimulus against a reference model
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem, freq;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [3:0]  sc;
  logic        wdt;

  always #5 clk = ~clk;

  pipe_ctrl #(.WDT_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(s_if), .stallreq_id(s_id), .stallreq_ex(s_ex), .stallreq_mem(s_mem),
    .flush_req(freq), .epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(sc), .wdt_timeout(wdt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // reference model: pending handler PCs in a queue, counters as plain integers
  logic [31:0] m_pend[$];
  int          m_sc, m_run;
  bit          m_wdt;

  function automatic void model_comb(output logic [5:0] es, output logic ef, output logic [31:0] ep);
    int depth;
    depth = s_mem ? 5 : s_ex ? 4 : s_id ? 3 : s_if ? 2 : 0;
    es = 6'((1 << depth) - 1);
    ef = 1'b0;
    ep = 32'h0;
    if (m_pend.size() > 0) begin
      if (!s_mem) begin es = 6'h0; ef = 1'b1; ep = m_pend[0]; end
    end else if (freq && !s_mem) begin
      es = 6'h0; ef = 1'b1; ep = epc;
    end
  endfunction

  function automatic void model_clock(input logic [5:0] es);
    if (m_pend.size() > 0) begin
      if (!s_mem) void'(m_pend.pop_front());
    end else if (freq && s_mem) m_pend.push_back(epc);
    if (es[0]) begin
      m_sc  = (m_sc < 15) ? m_sc + 1 : 15;
      m_run = (m_run < 4) ? m_run + 1 : 4;
      if (m_run == 4) m_wdt = 1'b1;
    end else m_run = 0;
  endfunction

  task automatic set_in(input logic [4:0] v, input logic [31:0] e);
    {s_mem, s_ex, s_id, s_if, freq} = v;
    epc = e;
  endtask

  task automatic cycle();
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    @(negedge clk);
    model_comb(es, ef, ep);
    chk("stall", {26'h0, stall}, {26'h0, es});
    chk("flush", {31'h0, flush}, {31'h0, ef});
    chk("new_pc", new_pc, ep);
    model_clock(es);
    @(posedge clk);
    #1;
    chk("stall_cycles", {28'h0, sc}, 32'(m_sc));
    chk("wdt_timeout", {31'h0, wdt}, {31'h0, m_wdt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_stall", {26'h0, stall}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_stall_cycles", {28'h0, sc}, 32'h0);
    chk("rst_wdt", {31'h0, wdt}, 32'h0);
    m_pend.delete();
    m_sc = 0; m_run = 0; m_wdt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  in;
    logic [31:0] epc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[10];

  initial begin
    // inputs packed as {mem, ex, id, if, flush_req}
    vecs[0] = '{5'b00000, 32'h0,        6'h00, 1'b0, 32'h0};
    vecs[1] = '{5'b00010, 32'h0,        6'h03, 1'b0, 32'h0};
    vecs[2] = '{5'b00100, 32'h0,        6'h07, 1'b0, 32'h0};
    vecs[3] = '{5'b01000, 32'h0,        6'h0f, 1'b0, 32'h0};
    vecs[4] = '{5'b10000, 32'h0,        6'h1f, 1'b0, 32'h0};
    vecs[5] = '{5'b01100, 32'h0,        6'h0f, 1'b0, 32'h0};
    vecs[6] = '{5'b11110, 32'h0,        6'h1f, 1'b0, 32'h0};
    vecs[7] = '{5'b00001, 32'hBFC00380, 6'h00, 1'b1, 32'hBFC00380};
    vecs[8] = '{5'b01111, 32'h00001234, 6'h00, 1'b1, 32'h00001234};
    vecs[9] = '{5'b00001, 32'h00000055, 6'h00, 1'b1, 32'h00000055};
    set_in(5'b0, 32'h0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].in, vecs[i].epc);
      #2;
      chk($sformatf("vec%0d_stall", i), {26'h0, stall}, {26'h0, vecs[i].st});
      chk($sformatf("vec%0d_flush", i), {31'h0, flush}, {31'h0, vecs[i].fl});
      chk($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].pc);
      cycle();
    end

    // deferred flush: first request wins, flush emitted once memory is idle
    set_in(5'b0, 32'h0);
    do_reset();
    set_in(5'b10001, 32'h80000180);
    #2 chk("pend_enter_stall", {26'h0, stall}, 32'h1f);
    chk("pend_enter_flush", {31'h0, flush}, 32'h0);
    cycle();
    set_in(5'b10001, 32'h0);
    cycle();
    set_in(5'b10000, 32'h0);
    #2 chk("pend_hold_stall", {26'h0, stall}, 32'h1f);
    cycle();
    set_in(5'b00000, 32'h0);
    #2 chk("pend_flush", {31'h0, flush}, 32'h1);
    chk("pend_new_pc", new_pc, 32'h80000180);
    chk("pend_flush_stall", {26'h0, stall}, 32'h0);
    cycle();
    #2 chk("pend_done_flush", {31'h0, flush}, 32'h0);
    chk("pend_done_stall_cycles", {28'h0, sc}, 32'h3);
    cycle();

    // watchdog: a 3-cycle run stays clear, a 4-cycle run trips and sticks
    do_reset();
    set_in(5'b01000, 32'h0);
    repeat (3) cycle();
    set_in(5'b00000, 32'h0);
    cycle();
    chk("wdt_short_run", {31'h0, wdt}, 32'h0);
    set_in(5'b01000, 32'h0);
    repeat (3) cycle();
    chk("wdt_before_4th", {31'h0, wdt}, 32'h0);
    cycle();
    chk("wdt_after_4th", {31'h0, wdt}, 32'h1);
    set_in(5'b00000, 32'h0);
    repeat (3) cycle();
    chk("wdt_sticky", {31'h0, wdt}, 32'h1);

    // reset while a flush is pending drops it
    do_reset();
    set_in(5'b10001, 32'hDEADBEEF);
    cycle();
    do_reset();
    set_in(5'b00000, 32'h0);
    #2 chk("post_rst_flush", {31'h0, flush}, 32'h0);
    chk("post_rst_new_pc", new_pc, 32'h0);
    cycle();

    // stall-cycle counter saturation
    do_reset();
    set_in(5'b00010, 32'h0);
    repeat (20) cycle();
    chk("sc_saturated", {28'h0, sc}, 32'hF);

    // random traffic against the model, with occasional resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s_mem = ($urandom_range(0, 99) < 35);
      s_ex  = ($urandom_range(0, 99) < 25);
      s_id  = ($urandom_range(0, 99) < 25);
      s_if  = ($urandom_range(0, 99) < 25);
      freq  = ($urandom_range(0, 99) < 15);
      epc   = $urandom;
      if ($urandom_range(0, 49) == 0) do_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WDT_LIMIT, default 255: consecutive stalled cycles that trip the watchdog; legal range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the stall-cycle performance counter.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 stallreq_if  in  1  fetch not ready.
REQ-006 stallreq_id  in  1  load-use hazard.
REQ-007 stallreq_ex  in  1  multicycle EX op busy.
REQ-008 stallreq_mem  in  1  data memory transaction in progress.
REQ-009 flush_req  in  1  exception flush request, level.
REQ-010 epc_i  in  32  handler PC for flush_req.
REQ-011 stall  out  6  stall[0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; a stage register with stall[k]=1 and stall[k+1]=0 inserts a bubble.
REQ-012 flush  out  1  one-cycle pipeline flush pulse.
REQ-013 new_pc  out  32  redirect PC, valid only while flush=1, else 0.
REQ-014 stall_cycles  out  CNT_W  saturating count of cycles with stall[0]=1.
REQ-015 wdt_timeout  out  1  sticky watchdog flag.

Function
REQ-016 stall SHALL be combinational from the inputs and the FSM state: highest active source wins, MEM 6'b011111 > EX 6'b001111 > ID 6'b000111 > IF 6'b000011, none 6'b000000.
REQ-017 FSM states SHALL be RUN and PEND; reset state RUN.
REQ-018 In RUN with flush_req=1 and stallreq_mem=0: flush=1, new_pc=epc_i, stall=6'b000000 in the same cycle; state stays RUN.
REQ-019 In RUN with flush_req=1 and stallreq_mem=1: flush=0, stall=6'b011111, epc_i captured into a 32-bit hold register, next state PEND.
REQ-020 In PEND with stallreq_mem=1: stall=6'b011111, flush=0; flush_req and epc_i are ignored (first request wins).
REQ-021 In PEND with stallreq_mem=0: flush=1, new_pc=hold register, stall=6'b000000, next state RUN, regardless of other requests.
REQ-022 A flush_req held high across consecutive RUN cycles SHALL produce a flush pulse every such cycle; the exception unit deasserts it after one cycle.
REQ-023 flush SHALL override stallreq_if/id/ex in the same cycle.
REQ-024 stall_cycles SHALL increment by 1 each cycle stall[0]=1 and hold at all-ones when saturated.
REQ-025 A run counter (8 bit) SHALL increment each cycle stall[0]=1, clear to 0 on any cycle with stall[0]=0, and saturate at WDT_LIMIT.
REQ-026 wdt_timeout SHALL set on the edge where the run counter reaches WDT_LIMIT and remain 1 until reset; it does not alter stall.

Reset
REQ-027 On rst=1, asynchronously: state=RUN, hold register=0, run counter=0, stall_cycles=0, wdt_timeout=0; during reset stall=0, flush=0, new_pc=0.
REQ-028 Reset while in PEND SHALL drop the pending flush; no flush is emitted after reset is released.

Structure
REQ-029 Stall vector constants (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM) and the FSM state encoding SHALL live in the shared CPU defines package.
REQ-030 The run counter and watchdog flag SHALL be one sub-module, stall_wdt, parameterised by WDT_LIMIT.
REQ-031 No combinational path SHALL exist from flush_req to stall other than through REQ-018/019 decode.

Verification
REQ-032 stallreq_id=1 and stallreq_ex=1 in the same cycle -> stall=6'b001111, stall_cycles increments by 1.
REQ-033 RUN, flush_req=1, epc_i=32'hBFC00380, stallreq_mem=0 -> same cycle flush=1, new_pc=32'hBFC00380, stall=0.
REQ-034 flush_req=1 for 1 cycle with epc_i=32'h80000180 while stallreq_mem=1 for 3 more cycles, second flush_req with epc_i=32'h0 in PEND -> stall=6'b011111 for 3 cycles, then one flush cycle with new_pc=32'h80000180, then RUN.
REQ-035 WDT_LIMIT=4, stallreq_ex=1 for 4 cycles -> wdt_timeout=1 after the 4th edge and stays 1 after stallreq_ex drops; 3-cycle run -> stays 0.
REQ-036 rst pulsed in PEND -> all outputs 0 immediately, no flush after release.
REQ-037 CNT_W=4, stallreq_if held 20 cycles -> stall_cycles stops at 4'hF.
